// File: rtl/dbus_access_ctrl_if.sv
// Data-bus handshake signals for the memory-stage access controller.
// The common package carries the access-size encoding shared with the
// aligner and the bus side.

package common;
  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;
endpackage

interface dbus_access_ctrl_if;
  import common::*;

  logic        dreq_valid;
  logic [63:0] dreq_addr;
  msize_t      dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;

  modport master (
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data
  );

  modport slave (
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data
  );
endinterface

// File: rtl/dbus_access_ctrl.sv
// Memory-stage data-bus access controller: issues one load/store per
// instruction over a two-phase bus (address accept, then data return),
// stalls until done, and holds the extended load result until the
// pipeline advances.
// Optional feature: define DBUS_MISALIGN_TRAP_EN to turn the aligner's
// misalignment flag into a trap instead of issuing the access.
//
// state     | meaning
// ----------+-------------------------------------------------------
// IDLE      | no access outstanding; may issue combinationally
// WAIT_ADDR | request presented, waiting for address accept
// WAIT_DATA | address accepted, waiting for data return
// DONE      | result held in rdata until advance/flush
// DRAIN     | flushed access, swallowing its data return

module dbus_access_ctrl
  import common::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  msize_t      req_msize,
  input  logic        req_unsigned,
  input  logic [63:0] req_wd,
  input  logic [7:0]  req_strobe,
  input  logic        req_error,
  input  logic        advance,
  input  logic        flush,
  dbus_access_ctrl_if.master dbus,
  output logic        stall,
  output logic        resp_valid,
  output logic [63:0] rdata,
  output logic        exc_misalign
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_ADDR = 3'd1,
    WAIT_DATA = 3'd2,
    DONE      = 3'd3,
    DRAIN     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        drain_q, drain_d;
  logic        issue, capture;
  logic        trap;

  // request fields latched at issue so the bus sees stable values even
  // after a flush lets the pipeline replace req_*
  logic [63:0] addr_q, wd_q;
  msize_t      size_q;
  logic [7:0]  strobe_q;
  logic        write_q, uns_q;

  logic [63:0] cur_addr, cur_wd;
  msize_t      cur_size;
  logic [7:0]  cur_strobe;
  logic        cur_write, cur_uns;

  logic [63:0] rdata_q;

`ifdef DBUS_MISALIGN_TRAP_EN
  assign trap         = req_valid & req_error;
  assign exc_misalign = !reset && (state_q == IDLE) && trap;
`else
  logic unused_req_error;
  assign unused_req_error = req_error;
  assign trap             = 1'b0;
  assign exc_misalign     = 1'b0;
`endif

  function automatic logic [63:0] extract(input logic [63:0] d,
                                          input logic [2:0]  off,
                                          input msize_t      sz,
                                          input logic        uns);
    logic [63:0] s;
    logic [63:0] r;
    s = d >> {off, 3'b000};
    case (sz)
      MSIZE1:  r = uns ? {56'd0, s[7:0]}  : {{56{s[7]}},  s[7:0]};
      MSIZE2:  r = uns ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
      MSIZE4:  r = uns ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  // in IDLE the request is still on req_*; afterwards use the latched copy
  always_comb begin
    if (state_q == IDLE) begin
      cur_addr   = req_addr;
      cur_wd     = req_wd;
      cur_size   = req_msize;
      cur_strobe = req_strobe;
      cur_write  = req_write;
      cur_uns    = req_unsigned;
    end else begin
      cur_addr   = addr_q;
      cur_wd     = wd_q;
      cur_size   = size_q;
      cur_strobe = strobe_q;
      cur_write  = write_q;
      cur_uns    = uns_q;
    end
  end

  // next-state logic and bus handshake decisions
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    issue   = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        drain_d = 1'b0;
        if (req_valid && !flush && !trap) begin
          issue = 1'b1;
          if (dbus.dresp_addr_ok && dbus.dresp_data_ok) begin
            capture = 1'b1;
            state_d = DONE;
          end else if (dbus.dresp_addr_ok) begin
            state_d = WAIT_DATA;
          end else begin
            state_d = WAIT_ADDR;
          end
        end
      end
      WAIT_ADDR: begin
        if (dbus.dresp_addr_ok) begin
          drain_d = 1'b0;
          if (flush || drain_q) begin
            state_d = dbus.dresp_data_ok ? IDLE : DRAIN;
          end else if (dbus.dresp_data_ok) begin
            capture = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WAIT_DATA;
          end
        end else if (flush) begin
          drain_d = 1'b1;
        end
      end
      WAIT_DATA: begin
        if (flush) begin
          state_d = dbus.dresp_data_ok ? IDLE : DRAIN;
        end else if (dbus.dresp_data_ok) begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (advance || flush) state_d = IDLE;
      end
      DRAIN: begin
        if (dbus.dresp_data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, request latch and result register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      drain_q  <= 1'b0;
      addr_q   <= 64'd0;
      wd_q     <= 64'd0;
      size_q   <= MSIZE1;
      strobe_q <= 8'd0;
      write_q  <= 1'b0;
      uns_q    <= 1'b0;
      rdata_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (issue) begin
        addr_q   <= req_addr;
        wd_q     <= req_wd;
        size_q   <= req_msize;
        strobe_q <= req_strobe;
        write_q  <= req_write;
        uns_q    <= req_unsigned;
      end
      if (capture) begin
        rdata_q <= cur_write ? 64'd0
                             : extract(dbus.dresp_data, cur_addr[2:0], cur_size, cur_uns);
      end
    end
  end

  // bus request and pipeline-facing outputs, forced low while in reset
  always_comb begin
    dbus.dreq_valid  = !reset && (issue || state_q == WAIT_ADDR);
    dbus.dreq_addr   = dbus.dreq_valid ? cur_addr : 64'd0;
    dbus.dreq_size   = dbus.dreq_valid ? cur_size : MSIZE1;
    dbus.dreq_strobe = (dbus.dreq_valid && cur_write) ? cur_strobe : 8'd0;
    dbus.dreq_data   = dbus.dreq_valid ? cur_wd : 64'd0;
    stall = !reset && ((state_q == DRAIN) ||
                       (state_q == WAIT_ADDR && drain_q) ||
                       (req_valid && !trap && !flush && state_q != DONE));
    resp_valid = (state_q == DONE);
    rdata      = resp_valid ? rdata_q : 64'd0;
  end

endmodule
